uart_rx_ctrl: RTL and testbench

- Controller that sequences the UART receiver and sits between it and the system bus or consumer logic.
- Gates the receiver's enable and captures each received byte exactly once from the receiver's multi-cycle valid window.
- Buffers captured bytes in a small FIFO presented on a valid/ready interface.
- Reports break, overflow and end-of-frame (idle timeout) events.

---
 rtl/uart_rx_ctrl_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 67 ++++++
 rtl/uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl_pkg
// Shared definitions for the UART receive controller.
//   rx_state_e       : controller FSM encoding (OFF/ARMED/FRAME/BREAK)
//   DEF_CLK_HZ       : nominal system clock
//   DEF_BIT_RATE     : nominal line rate
//   DEF_IDLE_CYCLES  : default end-of-frame timeout, about 10 bit times
//   DEF_CNT_W        : default idle counter width (holds DEF_IDLE_CYCLES)
// -----------------------------------------------------------------------------
package uart_rx_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_OFF   = 2'b00,
      ST_ARMED = 2'b01,
      ST_FRAME = 2'b10,
      ST_BREAK = 2'b11
   } rx_state_e;

   localparam int unsigned DEF_CLK_HZ   = 100_000_000;
   localparam int unsigned DEF_BIT_RATE = 9600;

   // 10 bit times at the nominal rate, rounded up slightly past
   // DEF_CLK_HZ / DEF_BIT_RATE * 10 to leave margin for baud error.
   localparam int DEF_IDLE_CYCLES = 104170;
   localparam int DEF_CNT_W       = 20;

endpackage : uart_rx_ctrl_pkg

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Small synchronous FIFO holding received bytes. The head entry is presented
// straight from the storage registers, so a pushed byte is visible the cycle
// after the push edge.
// Ports:
//   clk, resetn          : clock, asynchronous active-low reset
//   push_i, data_i       : write request and data (ignored when full unless
//                          a pop happens in the same cycle)
//   pop_i                : read request (ignored when empty)
//   data_o               : head entry
//   full_o, empty_o      : status
//   level_o              : occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   level_o
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra wrap bit so full and empty are distinguishable.
   logic [AW:0]       wr_ptr_q;
   logic [AW:0]       rd_ptr_q;
   logic [WIDTH-1:0]  mem_q [DEPTH];
   logic              do_push;
   logic              do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign level_o = wr_ptr_q - rd_ptr_q;
   assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

   assign do_pop  = pop_i && !empty_o;
   // A pop frees the slot on the same edge, so a full FIFO can still accept.
   assign do_push = push_i && (!full_o || do_pop);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

endmodule : uart_rx_fifo

// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
// Sequences a UART receiver: gates its enable, captures each byte once on the
// falling edge of the receiver's valid window, buffers bytes in a FIFO with a
// valid/ready head, and flags break, overflow and end-of-frame (idle timeout).
// Ports:
//   clk, resetn            : clock, asynchronous active-low reset
//   cfg_en                 : software receive enable
//   recv_en                : enable to the receiver
//   recv_valid/break/data  : receiver byte window, break flag, data
//   rx_valid/ready/data    : FIFO head handshake
//   rx_break               : one-cycle pulse on entering the break state
//   rx_eof                 : one-cycle pulse on idle timeout after a frame
//   rx_overflow, ovf_clr   : sticky drop flag and its clear (set wins)
//   rx_level               : FIFO occupancy
// Optional build macro UART_RX_CTRL_STATS_EN adds rx_byte_count (wrapping
// count of stored bytes) and rx_drop_count (saturating count of drops), both
// cleared by ovf_clr.
// -----------------------------------------------------------------------------
module uart_rx_ctrl
   import uart_rx_ctrl_pkg::*;
#(
   parameter int FIFO_DEPTH  = 4,
   parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           cfg_en,
   output logic                           recv_en,
   input  logic                           recv_valid,
   input  logic                           recv_break,
   input  logic [7:0]                     recv_data,
   output logic                           rx_valid,
   input  logic                           rx_ready,
   output logic [7:0]                     rx_data,
   output logic                           rx_break,
   output logic                           rx_eof,
   output logic                           rx_overflow,
   input  logic                           ovf_clr,
   output logic [$clog2(FIFO_DEPTH):0]    rx_level
`ifdef UART_RX_CTRL_STATS_EN
   ,
   output logic [15:0]                    rx_byte_count,
   output logic [7:0]                     rx_drop_count
`endif
);

   rx_state_e         state_q, state_d;
   logic [CNT_W-1:0]  idle_cnt_q, idle_cnt_d;
   logic              recv_valid_q;
   logic              break_q;
   logic              rx_break_q;
   logic              rx_eof_q;
   logic              rx_overflow_q;

   logic              cap;
   logic              idle_done;
   logic              push;
   logic              enter_break;
   logic              eof_hit;
   logic              drop;
   logic              fifo_full;
   logic              fifo_empty;

   // The receiver holds valid for a whole stop bit; its falling edge marks the
   // one point where the byte is known stable, so capture exactly there.
   assign cap       = recv_valid_q && !recv_valid;
   assign idle_done = (idle_cnt_q == CNT_W'(IDLE_CYCLES - 1));

   always_comb begin
      state_d     = state_q;
      idle_cnt_d  = idle_cnt_q;
      push        = 1'b0;
      enter_break = 1'b0;
      eof_hit     = 1'b0;
      case (state_q)
         ST_OFF: begin
            idle_cnt_d = '0;
            if (cfg_en) begin
               state_d = ST_ARMED;
            end
         end
         ST_ARMED: begin
            idle_cnt_d = '0;
            if (cap) begin
               if (break_q) begin
                  state_d     = ST_BREAK;
                  enter_break = 1'b1;
               end else begin
                  state_d = ST_FRAME;
                  push    = 1'b1;
               end
            end
         end
         ST_FRAME: begin
            if (cap) begin
               idle_cnt_d = '0;
               if (break_q) begin
                  state_d     = ST_BREAK;
                  enter_break = 1'b1;
               end else begin
                  push = 1'b1;
               end
            end else if (idle_done) begin
               idle_cnt_d = '0;
               eof_hit    = 1'b1;
               state_d    = ST_ARMED;
            end else begin
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            // Line noise after a break is discarded but keeps the quiet
            // period from expiring.
            if (cap) begin
               idle_cnt_d = '0;
            end else if (idle_done) begin
               idle_cnt_d = '0;
               state_d    = ST_ARMED;
            end else begin
               idle_cnt_d = idle_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = ST_OFF;
            idle_cnt_d = '0;
         end
      endcase
      // Disabling wins over every transition, but a byte captured in this
      // same cycle has already been pushed above.
      if (!cfg_en) begin
         state_d = ST_OFF;
      end
   end

   // A full FIFO cannot pop unless the consumer is ready, so the drop test
   // only needs rx_ready.
   assign drop = push && fifo_full && !rx_ready;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q       <= ST_OFF;
         idle_cnt_q    <= '0;
         recv_valid_q  <= 1'b0;
         break_q       <= 1'b0;
         rx_break_q    <= 1'b0;
         rx_eof_q      <= 1'b0;
         rx_overflow_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_cnt_q   <= idle_cnt_d;
         recv_valid_q <= recv_valid;
         break_q      <= recv_break;
         rx_break_q   <= enter_break;
         rx_eof_q     <= eof_hit;
         if (drop) begin
            rx_overflow_q <= 1'b1;
         end else if (ovf_clr) begin
            rx_overflow_q <= 1'b0;
         end
      end
   end

   uart_rx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .resetn  (resetn),
      .push_i  (push),
      .data_i  (recv_data),
      .pop_i   (rx_ready),
      .data_o  (rx_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (rx_level)
   );

   assign recv_en     = (state_q != ST_OFF);
   assign rx_valid    = !fifo_empty;
   assign rx_break    = rx_break_q;
   assign rx_eof      = rx_eof_q;
   assign rx_overflow = rx_overflow_q;

`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] byte_cnt_q;
   logic [7:0]  drop_cnt_q;
   logic        push_ok;

   assign push_ok = push && !drop;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         byte_cnt_q <= '0;
         drop_cnt_q <= '0;
      end else begin
         // A clear and a same-cycle event leave the count at that one event.
         byte_cnt_q <= (ovf_clr ? 16'd0 : byte_cnt_q) + {15'd0, push_ok};
         if (ovf_clr) begin
            drop_cnt_q <= {7'd0, drop};
         end else if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_q <= drop_cnt_q + 8'd1;
         end
      end
   end

   assign rx_byte_count = byte_cnt_q;
   assign rx_drop_count = drop_cnt_q;
`endif

endmodule : uart_rx_ctrl

// File: tb/tb_uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl with a scoreboard: stimulus queues the bytes
// that must come out, a monitor pops and compares on every rx handshake.
// Short IDLE_CYCLES and valid windows keep the run brief.
// -----------------------------------------------------------------------------
module tb_uart_rx_ctrl;

   localparam int DEPTH = 4;
   localparam int IDLE  = 40;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       cfg_en = 1'b0;
   logic       recv_en;
   logic       recv_valid = 1'b0;
   logic       recv_break = 1'b0;
   logic [7:0] recv_data = 8'h00;
   logic       rx_valid;
   logic       rx_ready = 1'b0;
   logic [7:0] rx_data;
   logic       rx_break;
   logic       rx_eof;
   logic       rx_overflow;
   logic       ovf_clr = 1'b0;
   logic [2:0] rx_level;
`ifdef UART_RX_CTRL_STATS_EN
   logic [15:0] rx_byte_count;
   logic [7:0]  rx_drop_count;
`endif

   uart_rx_ctrl #(
      .FIFO_DEPTH  (DEPTH),
      .IDLE_CYCLES (IDLE),
      .CNT_W       (8)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .cfg_en      (cfg_en),
      .recv_en     (recv_en),
      .recv_valid  (recv_valid),
      .recv_break  (recv_break),
      .recv_data   (recv_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_data     (rx_data),
      .rx_break    (rx_break),
      .rx_eof      (rx_eof),
      .rx_overflow (rx_overflow),
      .ovf_clr     (ovf_clr),
      .rx_level    (rx_level)
`ifdef UART_RX_CTRL_STATS_EN
      ,
      .rx_byte_count (rx_byte_count),
      .rx_drop_count (rx_drop_count)
`endif
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         vectors = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];
   int         hs_cnt = 0;
   int         brk_cnt = 0;
   int         eof_cnt = 0;
   int         valid_cyc = 0;
   int         drop_cyc = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard monitor: samples on the falling edge, away from the DUT edge.
   task automatic monitor();
      forever begin
         @(negedge clk);
         if (resetn) begin
            if (rx_valid) valid_cyc++;
            if (rx_valid && rx_ready) begin
               hs_cnt++;
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL pop: got unexpected byte 0x%0h, expected none", rx_data);
               end else begin
                  chk("pop_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
               end
            end
            if (rx_break) brk_cnt++;
            if (rx_eof) eof_cnt++;
         end
      end
   endtask

   // One receiver byte: valid high for 'width' cycles, data and break held one
   // cycle past the falling edge, then 'gap' idle cycles.
   task automatic send(input logic [7:0] d, input bit brk, input int width,
                       input int gap, input bit expect_push, input bit ready_on_cap);
      if (expect_push) exp_q.push_back(d);
      recv_data  = d;
      recv_break = brk;
      recv_valid = 1'b1;
      repeat (width) tick();
      recv_valid = 1'b0;
      drop_cyc   = cyc;
      if (ready_on_cap) rx_ready = 1'b1;
      tick();
      if (ready_on_cap) rx_ready = 1'b0;
      recv_break = 1'b0;
      repeat (gap) tick();
   endtask

   task automatic drain();
      tick();
      rx_ready = 1'b1;
      for (int i = 0; i < 20 && rx_level != 3'd0; i++) tick();
      @(negedge clk);
      chk("drain_level", {29'h0, rx_level}, 32'd0);
   endtask

   // rx_eof is expected IDLE+1 edges after the edge where recv_valid fell.
   task automatic check_eof_timing();
      while (cyc < drop_cyc + IDLE) tick();
      @(negedge clk);
      chk("eof_before", {31'h0, rx_eof}, 32'd0);
      tick();
      @(negedge clk);
      chk("eof_pulse", {31'h0, rx_eof}, 32'd1);
      tick();
      @(negedge clk);
      chk("eof_after", {31'h0, rx_eof}, 32'd0);
   endtask

   initial begin
      int h0;
      fork
         monitor();
      join_none

      // Reset state
      repeat (3) tick();
      @(negedge clk);
      chk("rst_recv_en",  {31'h0, recv_en},     32'd0);
      chk("rst_rx_valid", {31'h0, rx_valid},    32'd0);
      chk("rst_rx_data",  {24'h0, rx_data},     32'd0);
      chk("rst_rx_break", {31'h0, rx_break},    32'd0);
      chk("rst_rx_eof",   {31'h0, rx_eof},      32'd0);
      chk("rst_ovf",      {31'h0, rx_overflow}, 32'd0);
      chk("rst_level",    {29'h0, rx_level},    32'd0);
      tick();
      resetn = 1'b1;
      tick();
      cfg_en = 1'b1;
      tick();
      tick();
      @(negedge clk);
      chk("recv_en_on", {31'h0, recv_en}, 32'd1);

      // 1: three bytes streamed with consumer ready, then end of frame
      tick();
      rx_ready = 1'b1;
      send(8'hA5, 1'b0, 8, 4, 1'b1, 1'b0);
      send(8'h3C, 1'b0, 8, 4, 1'b1, 1'b0);
      send(8'hFF, 1'b0, 8, 2, 1'b1, 1'b0);
      check_eof_timing();
      chk("t1_queue_empty", exp_q.size(), 32'd0);
      chk("t1_valid_cycles", valid_cyc, 32'd3);
      chk("t1_eof_count", eof_cnt, 32'd1);

      // 2: overflow with consumer stalled
      tick();
      rx_ready = 1'b0;
      for (int i = 1; i <= 6; i++) send(8'(i), 1'b0, 4, 2, (i <= DEPTH), 1'b0);
      @(negedge clk);
      chk("t2_level_full", {29'h0, rx_level}, 32'd4);
      chk("t2_ovf_set", {31'h0, rx_overflow}, 32'd1);
`ifdef UART_RX_CTRL_STATS_EN
      chk("t2_byte_count", {16'h0, rx_byte_count}, 32'd7);
      chk("t2_drop_count", {24'h0, rx_drop_count}, 32'd2);
`endif
      drain();
      chk("t2_queue_empty", exp_q.size(), 32'd0);
      chk("t2_ovf_sticky", {31'h0, rx_overflow}, 32'd1);
      tick();
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      @(negedge clk);
      chk("t2_ovf_clr", {31'h0, rx_overflow}, 32'd0);
`ifdef UART_RX_CTRL_STATS_EN
      chk("t2_byte_count_clr", {16'h0, rx_byte_count}, 32'd0);
      chk("t2_drop_count_clr", {24'h0, rx_drop_count}, 32'd0);
`endif
      repeat (IDLE + 5) tick();
      chk("t2_eof_count", eof_cnt, 32'd2);

      // 3: break, discarded byte during the quiet period, then a normal byte
      rx_ready = 1'b1;
      send(8'h00, 1'b1, 4, 2, 1'b0, 1'b0);
      chk("t3_break_pulse", brk_cnt, 32'd1);
      send(8'h55, 1'b0, 4, 2, 1'b0, 1'b0);
      repeat (IDLE + 5) tick();
      chk("t3_break_no_eof", eof_cnt, 32'd2);
      chk("t3_break_single", brk_cnt, 32'd1);
      chk("t3_nothing_pushed", hs_cnt, 32'd7);
      send(8'h66, 1'b0, 4, 2, 1'b1, 1'b0);
      repeat (IDLE + 5) tick();
      chk("t3_after_break", hs_cnt, 32'd8);
      chk("t3_eof_count", eof_cnt, 32'd3);

      // 4: capture into a full FIFO while the consumer pops the same cycle
      rx_ready = 1'b0;
      send(8'h11, 1'b0, 4, 2, 1'b1, 1'b0);
      send(8'h22, 1'b0, 4, 2, 1'b1, 1'b0);
      send(8'h33, 1'b0, 4, 2, 1'b1, 1'b0);
      send(8'h44, 1'b0, 4, 2, 1'b1, 1'b0);
      send(8'h77, 1'b0, 4, 2, 1'b1, 1'b1);
      @(negedge clk);
      chk("t4_level_still_full", {29'h0, rx_level}, 32'd4);
      chk("t4_no_ovf", {31'h0, rx_overflow}, 32'd0);
      drain();
      chk("t4_queue_empty", exp_q.size(), 32'd0);
      repeat (IDLE + 5) tick();
      chk("t4_eof_count", eof_cnt, 32'd4);

      // 5: disable mid-frame, later bytes ignored, buffered byte drains
      rx_ready = 1'b0;
      send(8'h81, 1'b0, 4, 2, 1'b1, 1'b0);
      cfg_en = 1'b0;
      @(negedge clk);
      chk("t5_recv_en_same", {31'h0, recv_en}, 32'd1);
      tick();
      @(negedge clk);
      chk("t5_recv_en_off", {31'h0, recv_en}, 32'd0);
      tick();
      send(8'h82, 1'b0, 4, 2, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_level_held", {29'h0, rx_level}, 32'd1);
      drain();
      chk("t5_queue_empty", exp_q.size(), 32'd0);

      // reset pulse mid-frame with a full FIFO and overflow pending
      tick();
      rx_ready = 1'b0;
      cfg_en   = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) send(8'h91 + 8'(i), 1'b0, 4, 2, 1'b0, 1'b0);
      @(negedge clk);
      chk("t5_pre_reset_level", {29'h0, rx_level}, 32'd4);
      tick();
      resetn = 1'b0;
      @(negedge clk);
      chk("mrst_recv_en",  {31'h0, recv_en},     32'd0);
      chk("mrst_rx_valid", {31'h0, rx_valid},    32'd0);
      chk("mrst_rx_data",  {24'h0, rx_data},     32'd0);
      chk("mrst_rx_break", {31'h0, rx_break},    32'd0);
      chk("mrst_rx_eof",   {31'h0, rx_eof},      32'd0);
      chk("mrst_ovf",      {31'h0, rx_overflow}, 32'd0);
      chk("mrst_level",    {29'h0, rx_level},    32'd0);
      tick();
      resetn = 1'b1;
      tick();

      // 6: very long valid window yields a single byte
      rx_ready = 1'b1;
      h0 = hs_cnt;
      send(8'hC3, 1'b0, 100, 2, 1'b1, 1'b0);
      repeat (IDLE + 5) tick();
      chk("t6_single_push", hs_cnt - h0, 32'd1);
      chk("t6_queue_empty", exp_q.size(), 32'd0);
      chk("t6_eof_count", eof_cnt, 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_uart_rx_ctrl
